// File: rtl/modbus_resp_framer.sv
// Modbus RTU 0x03/0x04 response framer: register fetch, CRC-16 and byte streaming.
// Optional MB_BROADCAST_MUTE_EN adds slave_id_in; broadcast requests complete silently.
module modbus_resp_framer #(
    parameter logic [7:0] SADDR   = 8'h01,
    parameter int         A_WIDTH = 8,
    parameter int         D_WIDTH = 16,
    parameter int         MAX_QTY = 125
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               start,
    input  logic [7:0]         func_code,
    input  logic [A_WIDTH-1:0] start_addr,
    input  logic [7:0]         quantity,
    input  logic               exc_start,
    input  logic [7:0]         exc_code,
`ifdef MB_BROADCAST_MUTE_EN
    input  logic [7:0]         slave_id_in,
`endif
    output logic [A_WIDTH-1:0] rd_addr,
    input  logic [D_WIDTH-1:0] rd_data,
    output logic [7:0]         tx_byte,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               busy,
    output logic               resp_done
);

    typedef enum logic [3:0] {
        S_IDLE, S_HDR, S_FETCH, S_WAIT, S_DHI, S_DLO, S_CRCL, S_CRCH, S_DONE
    } state_t;

    localparam logic [7:0] MAX_Q8 = 8'(MAX_QTY);

    state_t               state_reg, state_next;
    logic [1:0]           hdr_idx_reg, hdr_idx_next;
    logic [7:0]           func_reg, func_next;
    logic [7:0]           hdr3_reg, hdr3_next;
    logic                 exc_reg, exc_next;
    logic [A_WIDTH-1:0]   addr_reg, addr_next;
    logic [7:0]           remain_reg, remain_next;
    logic [D_WIDTH-1:0]   data_reg, data_next;
    logic [15:0]          crc_reg, crc_next;
    logic [7:0]           tx_byte_c;
    logic                 tx_valid_c;
    logic                 fire;
    logic                 mute;

`ifdef MB_BROADCAST_MUTE_EN
    assign mute = (slave_id_in == 8'h00);
`else
    assign mute = 1'b0;
`endif

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int k = 0; k < 8; k++) begin
            r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        end
        return r;
    endfunction

    // Output byte is a pure function of held state, so it cannot change while stalled.
    always_comb begin
        tx_byte_c  = 8'h00;
        tx_valid_c = 1'b0;
        case (state_reg)
            S_HDR: begin
                tx_valid_c = 1'b1;
                case (hdr_idx_reg)
                    2'd0:    tx_byte_c = SADDR;
                    2'd1:    tx_byte_c = func_reg;
                    default: tx_byte_c = hdr3_reg;
                endcase
            end
            S_DHI: begin
                tx_valid_c = 1'b1;
                tx_byte_c  = data_reg[15:8];
            end
            S_DLO: begin
                tx_valid_c = 1'b1;
                tx_byte_c  = data_reg[7:0];
            end
            S_CRCL: begin
                tx_valid_c = 1'b1;
                tx_byte_c  = crc_reg[7:0];
            end
            S_CRCH: begin
                tx_valid_c = 1'b1;
                tx_byte_c  = crc_reg[15:8];
            end
            default: ;
        endcase
    end

    assign fire = tx_valid_c & tx_ready;

    always_comb begin
        state_next   = state_reg;
        hdr_idx_next = hdr_idx_reg;
        func_next    = func_reg;
        hdr3_next    = hdr3_reg;
        exc_next     = exc_reg;
        addr_next    = addr_reg;
        remain_next  = remain_reg;
        data_next    = data_reg;
        crc_next     = crc_reg;
        resp_done    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (exc_start || start) begin
                    crc_next     = 16'hFFFF;
                    hdr_idx_next = 2'd0;
                    state_next   = mute ? S_DONE : S_HDR;
                    if (exc_start) begin
                        func_next = func_code | 8'h80;
                        hdr3_next = exc_code;
                        exc_next  = 1'b1;
                    end else if (quantity == 8'd0 || quantity > MAX_Q8) begin
                        // Illegal quantity: exception 03, address register left untouched.
                        func_next = func_code | 8'h80;
                        hdr3_next = 8'h03;
                        exc_next  = 1'b1;
                    end else begin
                        func_next   = func_code;
                        hdr3_next   = {quantity[6:0], 1'b0};
                        exc_next    = 1'b0;
                        addr_next   = start_addr;
                        remain_next = quantity;
                    end
                end
            end
            S_HDR: begin
                if (fire) begin
                    crc_next = crc_upd(crc_reg, tx_byte_c);
                    if (hdr_idx_reg == 2'd2) begin
                        state_next = exc_reg ? S_CRCL : S_FETCH;
                    end else begin
                        hdr_idx_next = hdr_idx_reg + 2'd1;
                    end
                end
            end
            S_FETCH: state_next = S_WAIT;
            S_WAIT: begin
                data_next  = rd_data;
                state_next = S_DHI;
            end
            S_DHI: begin
                if (fire) begin
                    crc_next   = crc_upd(crc_reg, tx_byte_c);
                    state_next = S_DLO;
                end
            end
            S_DLO: begin
                if (fire) begin
                    crc_next    = crc_upd(crc_reg, tx_byte_c);
                    remain_next = remain_reg - 8'd1;
                    if (remain_reg == 8'd1) begin
                        state_next = S_CRCL;
                    end else begin
                        addr_next  = addr_reg + 1'b1;
                        state_next = S_FETCH;
                    end
                end
            end
            S_CRCL: if (fire) state_next = S_CRCH;
            S_CRCH: if (fire) state_next = S_DONE;
            S_DONE: begin
                resp_done  = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_reg   <= S_IDLE;
            hdr_idx_reg <= 2'd0;
            func_reg    <= 8'h00;
            hdr3_reg    <= 8'h00;
            exc_reg     <= 1'b0;
            addr_reg    <= '0;
            remain_reg  <= 8'd0;
            data_reg    <= '0;
            crc_reg     <= 16'hFFFF;
        end else begin
            state_reg   <= state_next;
            hdr_idx_reg <= hdr_idx_next;
            func_reg    <= func_next;
            hdr3_reg    <= hdr3_next;
            exc_reg     <= exc_next;
            addr_reg    <= addr_next;
            remain_reg  <= remain_next;
            data_reg    <= data_next;
            crc_reg     <= crc_next;
        end
    end

    assign rd_addr  = addr_reg;
    assign tx_byte  = tx_byte_c;
    assign tx_valid = tx_valid_c;
    assign busy     = (state_reg != S_IDLE);

endmodule

// File: tb/tb_modbus_resp_framer.sv
// Directed bench for modbus_resp_framer: frames collected off the tx handshake and compared bytewise.
module tb_modbus_resp_framer;

    typedef logic [7:0] bq_t[$];

    logic        clk;
    logic        rst_n_in;
    logic        start;
    logic [7:0]  func_code;
    logic [7:0]  start_addr;
    logic [7:0]  quantity;
    logic        exc_start;
    logic [7:0]  exc_code;
    logic [7:0]  rd_addr;
    logic [15:0] rd_data;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        resp_done;

    logic [15:0] mem [0:255];
    bq_t         rx_q;
    bq_t         addr_log;
    logic [7:0]  last_addr;
    int          done_cnt;
    int          n_cmp;
    int          n_bad;
    bit          bp_en;
    bit          stall_prev;
    logic [7:0]  stall_byte;

    modbus_resp_framer #(.SADDR(8'h01), .A_WIDTH(8), .D_WIDTH(16), .MAX_QTY(125)) dut (
        .clk_in     (clk),
        .rst_n_in   (rst_n_in),
        .start      (start),
        .func_code  (func_code),
        .start_addr (start_addr),
        .quantity   (quantity),
        .exc_start  (exc_start),
        .exc_code   (exc_code),
`ifdef MB_BROADCAST_MUTE_EN
        .slave_id_in(8'h01),
`endif
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .tx_byte    (tx_byte),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .resp_done  (resp_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= mem[rd_addr];

    always @(posedge clk) begin
        #1;
        tx_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] crc_of(input bq_t q);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (q[i]) begin
            c = c ^ {8'h00, q[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    // Monitor: collects accepted bytes, checks hold-while-stalled, logs rd_addr moves.
    always @(negedge clk) begin
        if (tx_valid === 1'b1 && tx_ready === 1'b1) rx_q.push_back(tx_byte);
        if (stall_prev) begin
            check_eq("hold_valid", 32'(tx_valid), 32'd1);
            check_eq("hold_byte", 32'(tx_byte), 32'(stall_byte));
        end
        stall_prev = (tx_valid === 1'b1) && (tx_ready === 1'b0);
        stall_byte = tx_byte;
        if (rd_addr !== last_addr && !$isunknown(rd_addr)) begin
            addr_log.push_back(rd_addr);
            last_addr = rd_addr;
        end
        if (resp_done === 1'b1) done_cnt++;
    end

    task automatic issue(input bit s, input bit e, input logic [7:0] fc, input logic [7:0] ad,
                         input logic [7:0] q, input logic [7:0] ec);
        @(posedge clk); #1;
        start = s; exc_start = e; func_code = fc; start_addr = ad; quantity = q; exc_code = ec;
        @(posedge clk); #1;
        start = 1'b0; exc_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int base);
        int n;
        n = 0;
        while (done_cnt == base && n < 5000) begin
            @(negedge clk); #2;
            n++;
        end
        check_eq({tag, "_done"}, 32'(done_cnt - base), 32'd1);
        @(negedge clk); #2;
        check_eq({tag, "_busy_after"}, 32'(busy), 32'd0);
        $display("frame %s: %0d bytes, crc residue %04h", tag, rx_q.size(), crc_of(rx_q));
    endtask

    task automatic run(input string tag, input bit s, input bit e, input logic [7:0] fc,
                       input logic [7:0] ad, input logic [7:0] q, input logic [7:0] ec);
        int base;
        rx_q.delete();
        addr_log.delete();
        base = done_cnt;
        issue(s, e, fc, ad, q, ec);
        wait_done(tag, base);
    endtask

    // exp holds the non-CRC bytes (or full frame when with_crc=0); CRC is checked by residue.
    task automatic check_frame(input string tag, input bq_t exp, input bit with_crc);
        int n_exp;
        n_exp = exp.size() + (with_crc ? 2 : 0);
        check_eq({tag, "_len"}, 32'(rx_q.size()), 32'(n_exp));
        foreach (exp[i]) begin
            if (i < rx_q.size()) check_eq($sformatf("%s_b%0d", tag, i), 32'(rx_q[i]), 32'(exp[i]));
        end
        if (with_crc && rx_q.size() == n_exp) check_eq({tag, "_crc_residue"}, 32'(crc_of(rx_q)), 32'd0);
    endtask

    initial begin
        bq_t exp;
        int  base;
        int  n;
        n_cmp = 0; n_bad = 0; done_cnt = 0; bp_en = 1'b0;
        stall_prev = 1'b0; stall_byte = 8'h00; last_addr = 8'h00;
        rst_n_in = 1'b0; start = 1'b0; exc_start = 1'b0; tx_ready = 1'b1;
        func_code = 8'h00; start_addr = 8'h00; quantity = 8'h00; exc_code = 8'h00;
        mem[8'h00] = 16'h1235; mem[8'h01] = 16'h2351; mem[8'h02] = 16'h3516;
        mem[8'h03] = 16'hAAAA; mem[8'hFF] = 16'hBEEF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_tx_valid", 32'(tx_valid), 32'd0);
        check_eq("rst_tx_byte", 32'(tx_byte), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_resp_done", 32'(resp_done), 32'd0);
        check_eq("rst_rd_addr", 32'(rd_addr), 32'd0);
        rst_n_in = 1'b1;

        run("exc", 1'b0, 1'b1, 8'h03, 8'h00, 8'h00, 8'h02);
        exp = '{8'h01, 8'h83, 8'h02, 8'hC0, 8'hF1};
        check_frame("exc", exp, 1'b0);

        run("norm", 1'b1, 1'b0, 8'h04, 8'h00, 8'h04, 8'h00);
        exp = '{8'h01, 8'h04, 8'h08, 8'h12, 8'h35, 8'h23, 8'h51, 8'h35, 8'h16, 8'hAA, 8'hAA};
        check_frame("norm", exp, 1'b1);

        bp_en = 1'b1;
        run("bp", 1'b1, 1'b0, 8'h04, 8'h00, 8'h04, 8'h00);
        bp_en = 1'b0;
        check_frame("bp", exp, 1'b1);

        run("qty0", 1'b1, 1'b0, 8'h04, 8'h10, 8'h00, 8'h00);
        exp = '{8'h01, 8'h84, 8'h03};
        check_frame("qty0", exp, 1'b1);
        check_eq("qty0_addr_moves", 32'(addr_log.size()), 32'd0);
        run("qty126", 1'b1, 1'b0, 8'h04, 8'h10, 8'd126, 8'h00);
        check_frame("qty126", exp, 1'b1);
        check_eq("qty126_addr_moves", 32'(addr_log.size()), 32'd0);

        run("wrap", 1'b1, 1'b0, 8'h03, 8'hFF, 8'h02, 8'h00);
        exp = '{8'h01, 8'h03, 8'h04, 8'hBE, 8'hEF, 8'h12, 8'h35};
        check_frame("wrap", exp, 1'b1);
        check_eq("wrap_addr_moves", 32'(addr_log.size()), 32'd2);
        if (addr_log.size() == 2) begin
            check_eq("wrap_addr0", 32'(addr_log[0]), 32'hFF);
            check_eq("wrap_addr1", 32'(addr_log[1]), 32'h00);
        end

        // Second start arrives mid-frame and must be ignored.
        rx_q.delete();
        addr_log.delete();
        base = done_cnt;
        issue(1'b1, 1'b0, 8'h03, 8'h01, 8'h01, 8'h00);
        repeat (2) @(negedge clk);
        issue(1'b1, 1'b0, 8'h04, 8'h02, 8'h04, 8'h00);
        wait_done("midstart", base);
        exp = '{8'h01, 8'h03, 8'h02, 8'h23, 8'h51};
        check_frame("midstart", exp, 1'b1);
        repeat (20) @(negedge clk);
        #2;
        check_eq("midstart_no_2nd_frame", 32'(done_cnt - base), 32'd1);
        check_eq("midstart_idle_busy", 32'(busy), 32'd0);

        run("collide", 1'b1, 1'b1, 8'h03, 8'h00, 8'h02, 8'h01);
        exp = '{8'h01, 8'h83, 8'h01};
        check_frame("collide", exp, 1'b1);

        // Reset while the first data-high byte is on the bus.
        rx_q.delete();
        base = done_cnt;
        issue(1'b1, 1'b0, 8'h04, 8'h00, 8'h04, 8'h00);
        n = 0;
        while (rx_q.size() < 4 && n < 200) begin
            @(negedge clk); #2;
            n++;
        end
        check_eq("rst_mid_reached_dhi", 32'(rx_q.size()), 32'd4);
        rst_n_in = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_mid_tx_valid", 32'(tx_valid), 32'd0);
        check_eq("rst_mid_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n_in = 1'b1;
        repeat (5) @(negedge clk);
        #2;
        check_eq("rst_mid_no_done", 32'(done_cnt - base), 32'd0);
        run("after_rst", 1'b1, 1'b0, 8'h04, 8'h00, 8'h04, 8'h00);
        exp = '{8'h01, 8'h04, 8'h08, 8'h12, 8'h35, 8'h23, 8'h51, 8'h35, 8'h16, 8'hAA, 8'hAA};
        check_frame("after_rst", exp, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
